// File: rtl/vend_pkg.sv
// Shared types and constants for the multi-denomination vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    localparam int SALES_W = 16;

endpackage

// File: rtl/credit_accum.sv
// Credit register with ceiling-checked coin add, price subtract and clear.
module credit_accum
    import vend_pkg::*;
#(
    parameter int COIN_W     = 4,
    parameter int CREDIT_W   = 8,
    parameter int PRICE      = 5,
    parameter int MAX_CREDIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                add_en,
    input  logic [COIN_W-1:0]   add_val,
    input  logic                sub_en,
    input  logic                clr_en,
    output logic [CREDIT_W-1:0] credit,
    output logic                overflow,
    output logic                sufficient
);

    logic [CREDIT_W:0] sum;

    // One extra bit on the sum so the ceiling check never sees a wrapped value.
    always_comb begin
        sum        = {1'b0, credit} + {{(CREDIT_W + 1 - COIN_W){1'b0}}, add_val};
        overflow   = (sum > (CREDIT_W + 1)'(MAX_CREDIT));
        sufficient = (credit >= CREDIT_W'(PRICE));
    end

    // Credit register; clear wins over add, add over subtract.
    always_ff @(posedge clk) begin
        if (!rst) begin
            credit <= {CREDIT_W{1'b0}};
        end else if (clr_en) begin
            credit <= {CREDIT_W{1'b0}};
        end else if (add_en) begin
            credit <= sum[CREDIT_W-1:0];
        end else if (sub_en) begin
            credit <= credit - CREDIT_W'(PRICE);
        end else begin
            credit <= credit;
        end
    end

endmodule

// File: rtl/vending_fsm_multi.sv
// Multi-coin vending controller: credit, vend at fixed price, change, cancel.
// Define SALES_COUNT_EN to add a saturating sales_count output.
module vending_fsm_multi
    import vend_pkg::*;
#(
    parameter int N_PROD     = 4,
    parameter int COIN_W     = 4,
    parameter int CREDIT_W   = 8,
    parameter int PRICE      = 5,
    parameter int MAX_CREDIT = 15,
    parameter int SEL_W      = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [COIN_W-1:0]   coin_value,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel,
    input  logic                cancel,
    output logic                coin_reject,
    output logic                vend_valid,
    output logic [SEL_W-1:0]    vend_prod,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
`ifdef SALES_COUNT_EN
    ,
    output logic [SALES_W-1:0]  sales_count
`endif
);

    state_t state;
    logic   add_en;
    logic   sub_en;
    logic   clr_en;
    logic   overflow;
    logic   sufficient;
    logic   coin_ok;
    logic   sel_ok;

    credit_accum #(
        .COIN_W     (COIN_W),
        .CREDIT_W   (CREDIT_W),
        .PRICE      (PRICE),
        .MAX_CREDIT (MAX_CREDIT)
    ) u_accum (
        .clk        (clk),
        .rst        (rst),
        .add_en     (add_en),
        .add_val    (coin_value),
        .sub_en     (sub_en),
        .clr_en     (clr_en),
        .credit     (credit),
        .overflow   (overflow),
        .sufficient (sufficient)
    );

    // Credit operations follow cancel > coin > sel; busy states clear on the way to IDLE.
    always_comb begin
        add_en  = 1'b0;
        sub_en  = 1'b0;
        clr_en  = 1'b0;
        coin_ok = (coin_value != {COIN_W{1'b0}}) && !overflow;
        sel_ok  = ({1'b0, sel} < (SEL_W + 1)'(N_PROD)) && sufficient;
        case (state)
            IDLE, CREDIT: begin
                if (cancel) begin
                    clr_en = (state == CREDIT);
                end else if (coin_valid) begin
                    add_en = coin_ok;
                end else if (sel_valid) begin
                    sub_en = sel_ok;
                end else begin
                    add_en = 1'b0;
                end
            end
            VEND:    clr_en = (credit != {CREDIT_W{1'b0}});
            CHANGE:  clr_en = 1'b1;
            default: clr_en = 1'b1;
        endcase
    end

    // Controller state and registered outputs; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            coin_reject  <= 1'b0;
            vend_valid   <= 1'b0;
            vend_prod    <= {SEL_W{1'b0}};
            change_valid <= 1'b0;
            change_amt   <= {CREDIT_W{1'b0}};
            busy         <= 1'b0;
        end else begin
            coin_reject  <= 1'b0;
            vend_valid   <= 1'b0;
            change_valid <= 1'b0;
            busy         <= 1'b0;
            case (state)
                IDLE, CREDIT: begin
                    if (cancel) begin
                        if (state == CREDIT) begin
                            state        <= CHANGE;
                            change_valid <= 1'b1;
                            change_amt   <= credit;
                            busy         <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (coin_valid) begin
                        if (coin_ok) begin
                            state <= CREDIT;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end else if (sel_valid && sel_ok) begin
                        state      <= VEND;
                        vend_valid <= 1'b1;
                        vend_prod  <= sel;
                        busy       <= 1'b1;
                    end else begin
                        state <= state;
                    end
                end
                VEND: begin
                    if (credit != {CREDIT_W{1'b0}}) begin
                        state        <= CHANGE;
                        change_valid <= 1'b1;
                        change_amt   <= credit;
                        busy         <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                CHANGE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SALES_COUNT_EN
    // Count dispensed products, holding at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sales_count <= {SALES_W{1'b0}};
        end else if (vend_valid && (sales_count != {SALES_W{1'b1}})) begin
            sales_count <= sales_count + SALES_W'(1);
        end else begin
            sales_count <= sales_count;
        end
    end
`endif

endmodule

// File: tb/tb_vending_fsm_multi.sv
// Scoreboard bench for vending_fsm_multi: expected pulses queued by stimulus, checked by a monitor.
module tb_vending_fsm_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [3:0] coin_value;
    logic       sel_valid;
    logic [1:0] sel;
    logic       cancel;
    logic       coin_reject;
    logic       vend_valid;
    logic [1:0] vend_prod;
    logic       change_valid;
    logic [7:0] change_amt;
    logic [7:0] credit;
    logic       busy;
`ifdef SALES_COUNT_EN
    logic [15:0] sales_count;
`endif

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int kind;   // 0 reject, 1 vend, 2 change
        int value;  // vend_prod or change_amt
        int cred;   // credit visible alongside the pulse
    } exp_t;

    exp_t sb[$];

    vending_fsm_multi dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .sel_valid    (sel_valid),
        .sel          (sel),
        .cancel       (cancel),
        .coin_reject  (coin_reject),
        .vend_valid   (vend_valid),
        .vend_prod    (vend_prod),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .credit       (credit),
        .busy         (busy)
`ifdef SALES_COUNT_EN
        ,
        .sales_count  (sales_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        compared++;
        if (act != exp_v) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic push(input int kind, input int value, input int cred);
        exp_t e;
        e.kind  = kind;
        e.value = value;
        e.cred  = cred;
        sb.push_back(e);
    endtask

    task automatic apply(input logic cv, input int cval, input logic sv, input int s, input logic cn);
        coin_valid = cv;
        coin_value = 4'(cval);
        sel_valid  = sv;
        sel        = 2'(s);
        cancel     = cn;
        @(posedge clk);
        #1;
        coin_valid = 1'b0;
        coin_value = 4'd0;
        sel_valid  = 1'b0;
        sel        = 2'd0;
        cancel     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        int   kind_act;
        if (rst && (coin_reject || vend_valid || change_valid)) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_pulse: rej=%0b vend=%0b chg=%0b with empty queue at %0t",
                         coin_reject, vend_valid, change_valid, $time);
            end else begin
                e = sb.pop_front();
                kind_act = coin_reject ? 0 : (vend_valid ? 1 : 2);
                chk("pulse_kind", kind_act, e.kind);
                chk("pulse_onehot", int'(coin_reject) + int'(vend_valid) + int'(change_valid), 1);
                if (e.kind == 1) chk("vend_prod", int'(vend_prod), e.value);
                if (e.kind == 2) chk("change_amt", int'(change_amt), e.value);
                chk("credit_at_pulse", int'(credit), e.cred);
                chk("busy_at_pulse", int'(busy), (e.kind == 0) ? 0 : 1);
            end
        end
    end

    initial begin
        rst        = 1'b0;
        coin_valid = 1'b1;
        coin_value = 4'd3;
        sel_valid  = 1'b1;
        sel        = 2'd1;
        cancel     = 1'b0;

        // 1. Reset with coins driven
        repeat (2) @(posedge clk);
        #1;
        chk("reset_credit", int'(credit), 0);
        chk("reset_pulses", int'({coin_reject, vend_valid, change_valid, busy}), 0);
        chk("reset_regs", int'(vend_prod) + int'(change_amt), 0);
        coin_valid = 1'b0;
        coin_value = 4'd0;
        sel_valid  = 1'b0;
        sel        = 2'd0;
        rst        = 1'b1;
        idle(1);
        chk("post_reset_credit", int'(credit), 0);

        // 2. Coins 2,3 then sel 1: exact price, no change
        apply(1'b1, 2, 1'b0, 0, 1'b0);
        apply(1'b1, 3, 1'b0, 0, 1'b0);
        chk("credit_5", int'(credit), 5);
        push(1, 1, 0);
        apply(1'b0, 0, 1'b1, 1, 1'b0);
        idle(3);
        chk("t2_credit", int'(credit), 0);
        chk("t2_busy", int'(busy), 0);

        // 3. Coins 4,4 then sel 3: vend then change of 3
        apply(1'b1, 4, 1'b0, 0, 1'b0);
        apply(1'b1, 4, 1'b0, 0, 1'b0);
        push(1, 3, 3);
        push(2, 3, 0);
        apply(1'b0, 0, 1'b1, 3, 1'b0);
        idle(4);
        chk("t3_credit", int'(credit), 0);

        // 4. Overflow at 12 and zero-value coin are rejected
        apply(1'b1, 4, 1'b0, 0, 1'b0);
        apply(1'b1, 4, 1'b0, 0, 1'b0);
        apply(1'b1, 4, 1'b0, 0, 1'b0);
        chk("credit_12", int'(credit), 12);
        push(0, 0, 12);
        apply(1'b1, 4, 1'b0, 0, 1'b0);
        push(0, 0, 12);
        apply(1'b1, 0, 1'b0, 0, 1'b0);
        idle(1);
        chk("t4_credit_held", int'(credit), 12);
        apply(1'b1, 3, 1'b0, 0, 1'b0);
        chk("credit_at_ceiling", int'(credit), 15);
        push(2, 15, 0);
        apply(1'b0, 0, 1'b0, 0, 1'b1);
        idle(3);

        // 5. Cancel + coin + sel together at credit 7
        apply(1'b1, 7, 1'b0, 0, 1'b0);
        push(2, 7, 0);
        apply(1'b1, 3, 1'b1, 0, 1'b1);
        idle(3);
        chk("t5_credit", int'(credit), 0);

        // 6. Insufficient credit: sel ignored silently
        apply(1'b1, 4, 1'b0, 0, 1'b0);
        apply(1'b0, 0, 1'b1, 2, 1'b0);
        idle(2);
        chk("t6_credit", int'(credit), 4);
        push(2, 4, 0);
        apply(1'b0, 0, 1'b0, 0, 1'b1);
        idle(3);

        // Third vend for the optional counter
        apply(1'b1, 5, 1'b0, 0, 1'b0);
        push(1, 0, 0);
        apply(1'b0, 0, 1'b1, 0, 1'b0);
        idle(4);
        chk("final_credit", int'(credit), 0);
`ifdef SALES_COUNT_EN
        chk("sales_count", int'(sales_count), 3);
`endif

        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
